alu_result_display: RTL and testbench

- Downstream consumer of the 2-operand ALU's 6-bit result (0..63).
- Converts the result to two BCD digits with a sequential double-dabble engine (one iteration per clock).
- Drives a time-multiplexed two-digit seven-segment display.
- Sits between the ALU output and the board display pins; the BCD digits are also exported for other consumers.

---
 rtl/alu_result_display.sv | 155 +++++++++++++++
 tb/tb_alu_result_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display
//
// Purpose:
//   Takes the 6-bit unsigned result of the two-operand ALU, converts it to two
//   BCD digits with a sequential double-dabble engine (one iteration per
//   clock), and drives a time-multiplexed two-digit seven-segment display.
//   The BCD digits are also exported for other consumers.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   result    in   [DATA_W-1:0] unsigned ALU result
//   valid     in   one-cycle strobe, result is stable this cycle
//   busy      out  conversion in progress; valid is ignored while high
//   done      out  one-cycle pulse, new BCD digits are on the outputs
//   bcd_tens  out  [3:0] tens digit (0..6)
//   bcd_ones  out  [3:0] ones digit (0..9)
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}
//   an        out  [1:0] digit enables, an[0] = ones, an[1] = tens
// ---------------------------------------------------------------------------
module alu_result_display #(
    parameter int DATA_W         = 6,
    parameter int REFRESH_BITS   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] result,
    input  logic              valid,
    output logic              busy,
    output logic              done,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic [6:0]        seg,
    output logic [1:0]        an
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_CONV = 1'b1;

    // Shift register layout: {tens nibble, ones nibble, binary input}
    localparam int SR_W = 8 + DATA_W;

    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_POL  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    localparam logic [2:0] LAST_ITER = 3'(DATA_W - 1);

    logic                    r_state;
    logic [SR_W-1:0]         r_shift;
    logic [2:0]              r_iter;
    logic                    r_done;
    logic [3:0]              r_tens;
    logic [3:0]              r_ones;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [6:0]              r_seg;
    logic [1:0]              r_an;

    logic [SR_W-1:0]         w_adj;
    logic [SR_W-1:0]         w_shifted;
    logic                    w_tens_sel;
    logic [3:0]              w_digit;
    logic [6:0]              w_seg_ah;
    logic [1:0]              w_an_ah;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Active-high gfedcba glyphs for 0..9
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // One double-dabble step: correct both BCD nibbles, then shift left.
    always_comb begin
        w_adj                = r_shift;
        w_adj[SR_W-1 -: 4]   = add3(r_shift[SR_W-1 -: 4]);
        w_adj[SR_W-5 -: 4]   = add3(r_shift[SR_W-5 -: 4]);
        w_shifted            = {w_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_iter  <= '0;
            r_done  <= 1'b0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (valid) begin
                    r_shift <= {8'd0, result};
                    r_iter  <= 3'd0;
                    r_state <= S_CONV;
                end
            end else begin
                r_shift <= w_shifted;
                r_iter  <= r_iter + 3'd1;
                // Digits are taken straight from the final step so the
                // outputs only ever see a completed conversion.
                if (r_iter == LAST_ITER) begin
                    r_tens  <= w_shifted[SR_W-1 -: 4];
                    r_ones  <= w_shifted[SR_W-5 -: 4];
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // Display: counter MSB picks the digit; tens is blanked when zero but its
    // enable stays asserted so the scan cadence is unchanged.
    always_comb begin
        w_tens_sel = r_scan[REFRESH_BITS-1];
        w_digit    = w_tens_sel ? r_tens : r_ones;
        w_seg_ah   = (w_tens_sel && (r_tens == 4'd0)) ? 7'h00 : glyph(w_digit);
        w_an_ah    = w_tens_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_seg  <= glyph(4'd0) ^ SEG_POL;
            r_an   <= 2'b01 ^ AN_POL;
        end else begin
            r_scan <= r_scan + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            r_seg  <= w_seg_ah ^ SEG_POL;
            r_an   <= w_an_ah ^ AN_POL;
        end
    end

    assign busy     = (r_state == S_CONV);
    assign done     = r_done;
    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] result;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_display #(
        .DATA_W(6),
        .REFRESH_BITS(3),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .result(result),
        .valid(valid),
        .busy(busy),
        .done(done),
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        valid  = 1'b0;
        result = 6'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (bcd_tens !== 4'd0) begin n_fail++; $display("FAIL reset_tens: got %0d want 0", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd0) begin n_fail++; $display("FAIL reset_ones: got %0d want 0", bcd_ones); end
        n_checks++; if (an !== 2'b10) begin n_fail++; $display("FAIL reset_an: got %b want 10", an); end
        n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %h want 40", seg); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_convert();
        logic [5:0] vin   [4];
        logic [3:0] exp_t [4];
        logic [3:0] exp_o [4];
        logic [6:0] exp_st[4];
        logic [6:0] exp_so[4];
        logic [6:0] seg_t;
        logic [6:0] seg_o;
        vin[0] = 6'd42; exp_t[0] = 4'd4; exp_o[0] = 4'd2; exp_st[0] = 7'h19; exp_so[0] = 7'h24;
        vin[1] = 6'd63; exp_t[1] = 4'd6; exp_o[1] = 4'd3; exp_st[1] = 7'h02; exp_so[1] = 7'h30;
        vin[2] = 6'd9;  exp_t[2] = 4'd0; exp_o[2] = 4'd9; exp_st[2] = 7'h7F; exp_so[2] = 7'h10;
        vin[3] = 6'd0;  exp_t[3] = 4'd0; exp_o[3] = 4'd0; exp_st[3] = 7'h7F; exp_so[3] = 7'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid  = 1'b1;
            result = vin[i];
            @(negedge clk);
            valid = 1'b0;
            for (int c = 0; c < 6; c++) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL conv_busy[%0d] cycle %0d: got busy=%b done=%b want busy=1 done=0", vin[i], c, busy, done);
                end
                @(negedge clk);
            end
            n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL conv_done[%0d]: got done=%b busy=%b want done=1 busy=0", vin[i], done, busy); end
            n_checks++; if (bcd_tens !== exp_t[i]) begin n_fail++; $display("FAIL conv_tens[%0d]: got %0d want %0d", vin[i], bcd_tens, exp_t[i]); end
            n_checks++; if (bcd_ones !== exp_o[i]) begin n_fail++; $display("FAIL conv_ones[%0d]: got %0d want %0d", vin[i], bcd_ones, exp_o[i]); end
            seg_t = 7'bx;
            seg_o = 7'bx;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL conv_done_pulse[%0d]: got %b want 0", vin[i], done); end
                end
                if (an === 2'b01) seg_t = seg;
                else if (an === 2'b10) seg_o = seg;
            end
            n_checks++; if (seg_t !== exp_st[i]) begin n_fail++; $display("FAIL conv_seg_tens[%0d]: got %h want %h", vin[i], seg_t, exp_st[i]); end
            n_checks++; if (seg_o !== exp_so[i]) begin n_fail++; $display("FAIL conv_seg_ones[%0d]: got %h want %h", vin[i], seg_o, exp_so[i]); end
        end
    endtask

    task automatic test_ignore();
        int done_cnt = 0;
        @(negedge clk);
        valid  = 1'b1;
        result = 6'd42;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // third busy cycle
        valid  = 1'b1;
        result = 6'd5;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (bcd_tens !== 4'd4) begin n_fail++; $display("FAIL ignore_tens: got %0d want 4", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd2) begin n_fail++; $display("FAIL ignore_ones: got %0d want 2", bcd_ones); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid  = 1'b1;
        result = 6'd9;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 10 && done !== 1'b1; c++) @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        n_checks++; if (bcd_ones !== 4'd9) begin n_fail++; $display("FAIL b2b_first_ones: got %0d want 9", bcd_ones); end
        // valid during the done cycle
        valid  = 1'b1;
        result = 6'd17;
        @(negedge clk);
        valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", busy, done); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done cycle %0d: got %b want 0", c, done); end
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", done); end
        n_checks++; if (bcd_tens !== 4'd1) begin n_fail++; $display("FAIL b2b_tens: got %0d want 1", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd7) begin n_fail++; $display("FAIL b2b_ones: got %0d want 7", bcd_ones); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid  = 1'b1;
        result = 6'd63;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // fourth conversion cycle
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (bcd_tens !== 4'd0) begin n_fail++; $display("FAIL rmid_tens: got %0d want 0", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd0) begin n_fail++; $display("FAIL rmid_ones: got %0d want 0", bcd_ones); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet cycle %0d: got done=%b busy=%b want 0 0", c, done, busy); end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done cycle %0d: got %b want 0", c, done); end
        end
        valid  = 1'b1;
        result = 6'd25;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 10 && done !== 1'b1; c++) @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmid_after_done: got %b want 1", done); end
        n_checks++; if (bcd_tens !== 4'd2) begin n_fail++; $display("FAIL rmid_after_tens: got %0d want 2", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd5) begin n_fail++; $display("FAIL rmid_after_ones: got %0d want 5", bcd_ones); end
    endtask

    task automatic test_scan();
        logic [1:0] exp_an;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            exp_an = ((((n - 1) >> 2) & 1) != 0) ? 2'b01 : 2'b10;
            n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an edge %0d: got %b want %b", n, an, exp_an); end
            if (n >= 5 && n <= 8) begin
                n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL scan_blank edge %0d: got %h want 7f", n, seg); end
            end
            if (n >= 13 && n <= 16) begin
                n_checks++; if (seg !== 7'h02) begin n_fail++; $display("FAIL scan_seg_tens edge %0d: got %h want 02", n, seg); end
            end
            if (n >= 17) begin
                n_checks++; if (seg !== 7'h30) begin n_fail++; $display("FAIL scan_seg_ones edge %0d: got %h want 30", n, seg); end
            end
            if (n == 3) begin
                valid  = 1'b1;
                result = 6'd63;
            end else begin
                valid = 1'b0;
            end
        end
        n_checks++; if (bcd_tens !== 4'd6) begin n_fail++; $display("FAIL scan_tens: got %0d want 6", bcd_tens); end
        n_checks++; if (bcd_ones !== 4'd3) begin n_fail++; $display("FAIL scan_ones: got %0d want 3", bcd_ones); end
    endtask

    initial begin
        rst_n  = 1'b1;
        valid  = 1'b0;
        result = 6'd0;
        test_reset();
        test_convert();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
